// File: rtl/pacman_mover_pkg.sv
// Shared types and helpers for the grid-locked sprite mover: directions,
// FSM states, keyboard codes and direction helper functions.
package pacman_pkg;

  typedef enum logic [2:0] {
    NONE,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PROBE_TURN,
    WAIT_TURN,
    PROBE_FWD,
    WAIT_FWD,
    MOVE
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic dir_t dir_reverse(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      RIGHT:   return LEFT;
      default: return NONE;
    endcase
  endfunction

  // Any keycode outside the four movement keys is "no request".
  function automatic dir_t key_to_dir(input logic [7:0] key);
    case (key)
      KEY_W:   return UP;
      KEY_S:   return DOWN;
      KEY_A:   return LEFT;
      KEY_D:   return RIGHT;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/pacman_mover_if.sv
// Tile-map query handshake between the mover (master) and the maze map (slave).
interface pacman_mover_if;

  logic       map_req;
  logic [5:0] map_col;
  logic [5:0] map_row;
  logic       map_valid;
  logic       map_wall;

  modport master (
    output map_req,
    output map_col,
    output map_row,
    input  map_valid,
    input  map_wall
  );

  modport slave (
    input  map_req,
    input  map_col,
    input  map_row,
    output map_valid,
    output map_wall
  );

endinterface

// File: rtl/pacman_mover_tile_neighbour.sv
// Combinational neighbour-tile lookup: one step from (col,row) in dir, with
// out-of-range detection and the tunnel-row horizontal exception.
module tile_neighbour
  import pacman_pkg::*;
#(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int TUNNEL_ROW = 14
) (
  input  logic [5:0] col,
  input  logic [5:0] row,
  input  dir_t       dir,
  output logic [5:0] n_col,
  output logic [5:0] n_row,
  output logic       out_of_range,
  output logic       tunnel_open
);

  localparam logic [6:0] COLS_W   = 7'(COLS);
  localparam logic [6:0] ROWS_W   = 7'(ROWS);
  localparam logic [5:0] TUNNEL_W = 6'(TUNNEL_ROW);

  logic [6:0] col_ext;
  logic [6:0] row_ext;
  logic       horizontal;

  // One extra bit so that stepping off column/row 0 wraps to a large value
  // and is caught by the same range compare as stepping off the far edge.
  always_comb begin
    col_ext = {1'b0, col};
    row_ext = {1'b0, row};
    case (dir)
      UP:      row_ext = {1'b0, row} - 7'd1;
      DOWN:    row_ext = {1'b0, row} + 7'd1;
      LEFT:    col_ext = {1'b0, col} - 7'd1;
      RIGHT:   col_ext = {1'b0, col} + 7'd1;
      default: ;
    endcase
  end

  assign horizontal   = (dir == LEFT) || (dir == RIGHT);
  assign out_of_range = (col_ext >= COLS_W) || (row_ext >= ROWS_W);
  assign tunnel_open  = out_of_range && horizontal && (row == TUNNEL_W);
  assign n_col        = col_ext[5:0];
  assign n_row        = row_ext[5:0];

endmodule

// File: rtl/pacman_mover.sv
// Grid-locked sprite motion controller: once per frame it latches the key
// request, probes the tile map for walls and steps the sprite by SPEED pixels.
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int TILE       = 16,
  parameter int SPEED      = 2,
  parameter int SIZE       = 6,
  parameter int START_COL  = 13,
  parameter int START_ROW  = 23,
  parameter int TUNNEL_ROW = 14
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic [7:0]            keycode,
  pacman_mover_if.master        map,
  output logic [9:0]            PosX,
  output logic [9:0]            PosY,
  output logic [9:0]            Size,
  output logic [3:0]            last_dirX,
  output logic [3:0]            last_dirY,
  output logic                  busy,
  output logic                  tick_overrun
);

  localparam int         TILE_LOG2 = $clog2(TILE);
  localparam int         COLS      = SCREEN_W / TILE;
  localparam int         ROWS      = SCREEN_H / TILE;
  localparam logic [9:0] TILE_MASK = 10'(TILE - 1);
  localparam logic [9:0] HALF      = 10'(TILE / 2);
  localparam logic [9:0] STEP      = 10'(SPEED);
  localparam logic [9:0] X_START   = 10'(START_COL * TILE + TILE / 2);
  localparam logic [9:0] Y_START   = 10'(START_ROW * TILE + TILE / 2);
  localparam logic [9:0] X_WRAP_HI = 10'(SCREEN_W - TILE / 2);
  localparam logic [5:0] TUNNEL_W  = 6'(TUNNEL_ROW);

  state_t     state_reg,    state_next;
  logic [9:0] pos_x_reg,    pos_x_next;
  logic [9:0] pos_y_reg,    pos_y_next;
  dir_t       cur_dir_reg,  cur_dir_next;
  dir_t       pend_dir_reg, pend_dir_next;
  logic [3:0] last_x_reg,   last_x_next;
  logic [3:0] last_y_reg,   last_y_next;
  logic       overrun_reg,  overrun_next;

  logic [5:0] tile_col;
  logic [5:0] tile_row;
  logic       centred;
  logic       on_tunnel_row;
  dir_t       key_dir;
  dir_t       pend_eff;
  dir_t       probe_dir;
  logic [5:0] nb_col;
  logic [5:0] nb_row;
  logic       nb_oor;
  logic       nb_tunnel;
  logic       probing;
  logic       ans_valid;
  logic       ans_wall;

  assign tile_col      = 6'(pos_x_reg >> TILE_LOG2);
  assign tile_row      = 6'(pos_y_reg >> TILE_LOG2);
  assign centred       = ((pos_x_reg & TILE_MASK) == HALF) &&
                         ((pos_y_reg & TILE_MASK) == HALF);
  assign on_tunnel_row = (tile_row == TUNNEL_W);
  assign key_dir       = key_to_dir(keycode);
  assign pend_eff      = (key_dir != NONE) ? key_dir : pend_dir_reg;

  // A single neighbour lookup serves both probes; the turn probe looks
  // along the queued direction, the forward probe along the current one.
  assign probe_dir = ((state_reg == PROBE_TURN) || (state_reg == WAIT_TURN))
                   ? pend_dir_reg : cur_dir_reg;

  tile_neighbour #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .TUNNEL_ROW (TUNNEL_ROW)
  ) u_neighbour (
    .col          (tile_col),
    .row          (tile_row),
    .dir          (probe_dir),
    .n_col        (nb_col),
    .n_row        (nb_row),
    .out_of_range (nb_oor),
    .tunnel_open  (nb_tunnel)
  );

  assign probing       = (state_reg == PROBE_TURN) || (state_reg == PROBE_FWD);
  assign map.map_req   = probing && !nb_oor;
  assign map.map_col   = nb_col;
  assign map.map_row   = nb_row;

  // Out-of-range neighbours are answered locally in the probe cycle, so the
  // probe and wait states share the same answer-handling transitions.
  always_comb begin
    ans_valid = 1'b0;
    ans_wall  = 1'b0;
    case (state_reg)
      PROBE_TURN, PROBE_FWD: begin
        if (nb_oor) begin
          ans_valid = 1'b1;
          ans_wall  = !nb_tunnel;
        end
      end
      WAIT_TURN, WAIT_FWD: begin
        ans_valid = map.map_valid;
        ans_wall  = map.map_wall;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    pos_x_next    = pos_x_reg;
    pos_y_next    = pos_y_reg;
    cur_dir_next  = cur_dir_reg;
    pend_dir_next = pend_dir_reg;
    last_x_next   = last_x_reg;
    last_y_next   = last_y_reg;
    overrun_next  = overrun_reg;

    if (frame_tick && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          state_next = LATCH;
        end
      end

      LATCH: begin
        pend_dir_next = pend_eff;
        if ((pend_eff != NONE) && (pend_eff == dir_reverse(cur_dir_reg))) begin
          cur_dir_next  = pend_eff;
          pend_dir_next = NONE;
          state_next    = MOVE;
        end else if (centred && (pend_eff != NONE) && (pend_eff != cur_dir_reg)) begin
          state_next = PROBE_TURN;
        end else if (centred && (cur_dir_reg != NONE)) begin
          state_next = PROBE_FWD;
        end else begin
          state_next = MOVE;
        end
      end

      PROBE_TURN, WAIT_TURN: begin
        if (ans_valid) begin
          if (!ans_wall) begin
            cur_dir_next  = pend_dir_reg;
            pend_dir_next = NONE;
            state_next    = MOVE;
          end else if (cur_dir_reg != NONE) begin
            state_next = PROBE_FWD;
          end else begin
            state_next = IDLE;
          end
        end else if (state_reg == PROBE_TURN) begin
          state_next = WAIT_TURN;
        end
      end

      PROBE_FWD, WAIT_FWD: begin
        if (ans_valid) begin
          if (ans_wall) begin
            cur_dir_next = NONE;
            state_next   = IDLE;
          end else begin
            state_next = MOVE;
          end
        end else if (state_reg == PROBE_FWD) begin
          state_next = WAIT_FWD;
        end
      end

      MOVE: begin
        state_next = IDLE;
        case (cur_dir_reg)
          UP: begin
            pos_y_next  = pos_y_reg - STEP;
            last_x_next = 4'h0;
            last_y_next = 4'hF;
          end
          DOWN: begin
            pos_y_next  = pos_y_reg + STEP;
            last_x_next = 4'h0;
            last_y_next = 4'h1;
          end
          LEFT: begin
            if (on_tunnel_row && (pos_x_reg == HALF)) begin
              pos_x_next = X_WRAP_HI;
            end else begin
              pos_x_next = pos_x_reg - STEP;
            end
            last_x_next = 4'hF;
            last_y_next = 4'h0;
          end
          RIGHT: begin
            if (on_tunnel_row && (pos_x_reg == X_WRAP_HI)) begin
              pos_x_next = HALF;
            end else begin
              pos_x_next = pos_x_reg + STEP;
            end
            last_x_next = 4'h1;
            last_y_next = 4'h0;
          end
          default: ;
        endcase
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      pos_x_reg    <= X_START;
      pos_y_reg    <= Y_START;
      cur_dir_reg  <= NONE;
      pend_dir_reg <= NONE;
      last_x_reg   <= 4'h0;
      last_y_reg   <= 4'h0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pos_x_reg    <= pos_x_next;
      pos_y_reg    <= pos_y_next;
      cur_dir_reg  <= cur_dir_next;
      pend_dir_reg <= pend_dir_next;
      last_x_reg   <= last_x_next;
      last_y_reg   <= last_y_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign PosX         = pos_x_reg;
  assign PosY         = pos_y_reg;
  assign Size         = 10'(SIZE);
  assign last_dirX    = last_x_reg;
  assign last_dirY    = last_y_reg;
  assign busy         = (state_reg != IDLE);
  assign tick_overrun = overrun_reg;

endmodule

// File: tb/tb_pacman_mover.sv
// Self-checking bench for pacman_mover: frame-level behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_pacman_mover;

  localparam int D_NONE  = 0;
  localparam int D_UP    = 1;
  localparam int D_DOWN  = 2;
  localparam int D_LEFT  = 3;
  localparam int D_RIGHT = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] PosX, PosY, Size;
  logic [3:0] last_dirX, last_dirY;
  logic       busy, tick_overrun;

  pacman_mover_if bus ();

  pacman_mover dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .keycode      (keycode),
    .map          (bus),
    .PosX         (PosX),
    .PosY         (PosY),
    .Size         (Size),
    .last_dirX    (last_dirX),
    .last_dirY    (last_dirY),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side maze and responder controls
  bit walls [0:29][0:39];
  bit resp_en = 1'b1;
  int stale_cnt = 0;
  int stale_seen = 0;
  int req_cnt = 0;
  int tot_reqs = 0;

  // Frame-level model of the sprite
  int         mx, my, mcur, mpend, m_reqs;
  logic [3:0] m_ldx, m_ldy;
  bit         m_ovr;
  bit         model_sync = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'h1A:   return D_UP;
      8'h16:   return D_DOWN;
      8'h04:   return D_LEFT;
      8'h07:   return D_RIGHT;
      default: return D_NONE;
    endcase
  endfunction

  function automatic int opp(input int d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      D_RIGHT: return D_LEFT;
      default: return D_NONE;
    endcase
  endfunction

  function automatic int ddx(input int d);
    return (d == D_LEFT) ? -1 : (d == D_RIGHT) ? 1 : 0;
  endfunction

  function automatic int ddy(input int d);
    return (d == D_UP) ? -1 : (d == D_DOWN) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mx = 13 * 16 + 8;
    my = 23 * 16 + 8;
    mcur = D_NONE;
    mpend = D_NONE;
    m_ldx = 4'h0;
    m_ldy = 4'h0;
    m_ovr = 1'b0;
  endtask

  task automatic model_query(input int d, output bit open);
    int nc, nr;
    nc = mx / 16 + ddx(d);
    nr = my / 16 + ddy(d);
    if (nc < 0 || nc >= 40 || nr < 0 || nr >= 30) begin
      open = (nr == 14) && (ddx(d) != 0);
    end else begin
      m_reqs++;
      open = !walls[nr][nc];
    end
  endtask

  task automatic model_move();
    int nx;
    if (mcur == D_NONE) return;
    nx = mx + 2 * ddx(mcur);
    if (my / 16 == 14 && ddx(mcur) < 0 && mx == 8)   nx = 632;
    if (my / 16 == 14 && ddx(mcur) > 0 && mx == 632) nx = 8;
    mx = nx;
    my = my + 2 * ddy(mcur);
    m_ldx = (ddx(mcur) > 0) ? 4'h1 : (ddx(mcur) < 0) ? 4'hF : 4'h0;
    m_ldy = (ddy(mcur) > 0) ? 4'h1 : (ddy(mcur) < 0) ? 4'hF : 4'h0;
  endtask

  task automatic model_step(input logic [7:0] key);
    bit open;
    bit centred;
    m_reqs = 0;
    if (key_dir(key) != D_NONE) mpend = key_dir(key);
    centred = (mx % 16 == 8) && (my % 16 == 8);
    if (mpend != D_NONE && mpend == opp(mcur)) begin
      mcur = mpend;
      mpend = D_NONE;
      model_move();
    end else if (centred && mpend != D_NONE && mpend != mcur) begin
      model_query(mpend, open);
      if (open) begin
        mcur = mpend;
        mpend = D_NONE;
        model_move();
      end else if (mcur != D_NONE) begin
        model_query(mcur, open);
        if (open) model_move();
        else mcur = D_NONE;
      end
    end else if (centred && mcur != D_NONE) begin
      model_query(mcur, open);
      if (open) model_move();
      else mcur = D_NONE;
    end else begin
      model_move();
    end
  endtask

  // Tile-map responder: answers each request after 1..3 cycles, or injects
  // an unsolicited answer when asked.
  initial begin
    int c, r, lat;
    bus.map_valid = 1'b0;
    bus.map_wall  = 1'b0;
    forever begin
      @(negedge Clk);
      if (stale_cnt != stale_seen) begin
        stale_seen++;
        bus.map_valid = 1'b1;
        bus.map_wall  = 1'b0;
        @(negedge Clk);
        bus.map_valid = 1'b0;
      end else if (resp_en && bus.map_req) begin
        c = int'(bus.map_col);
        r = int'(bus.map_row);
        lat = $urandom_range(1, 3);
        repeat (lat) @(negedge Clk);
        bus.map_wall  = (r < 30 && c < 40) ? walls[r][c] : 1'b1;
        bus.map_valid = 1'b1;
        @(negedge Clk);
        bus.map_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (bus.map_req) req_cnt++;
    end
  end

  // Continuous comparison against the model whenever the mover is idle.
  initial begin
    forever begin
      @(negedge Clk);
      if (model_sync && Reset && !busy) begin
        chk("cmp_PosX", int'(PosX), mx);
        chk("cmp_PosY", int'(PosY), my);
        chk("cmp_last_dirX", int'(last_dirX), int'(m_ldx));
        chk("cmp_last_dirY", int'(last_dirY), int'(m_ldy));
        chk("cmp_tick_overrun", int'(tick_overrun), int'(m_ovr));
        chk("cmp_idle_map_req", int'(bus.map_req), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    if (busy) chk(name, 1, 0);
  endtask

  task automatic do_reset();
    model_sync = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    model_sync = 1'b1;
  endtask

  task automatic frame(input logic [7:0] key);
    model_sync = 1'b0;
    keycode = key;
    req_cnt = 0;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    wait_idle("frame_timeout");
    model_step(key);
    chk("frame_map_reqs", req_cnt, m_reqs);
    tot_reqs += req_cnt;
    model_sync = 1'b1;
    $display("frame key=%02h PosX=%0d PosY=%0d reqs=%0d", key, PosX, PosY, req_cnt);
  endtask

  task automatic frame_overrun(input logic [7:0] key);
    model_sync = 1'b0;
    keycode = key;
    req_cnt = 0;
    frame_tick = 1'b1;
    @(negedge Clk);
    chk("ovr_busy_pre", int'(busy), 1);
    @(negedge Clk);
    frame_tick = 1'b0;
    wait_idle("ovr_timeout");
    model_step(key);
    m_ovr = 1'b1;
    model_sync = 1'b1;
    $display("overrun frame key=%02h tick_overrun=%0d", key, tick_overrun);
  endtask

  initial begin
    int cyc;
    @(negedge Clk);
    do_reset();

    // Reset state
    chk("rst_PosX", int'(PosX), 216);
    chk("rst_PosY", int'(PosY), 376);
    chk("rst_last_dirX", int'(last_dirX), 0);
    chk("rst_last_dirY", int'(last_dirY), 0);
    chk("rst_map_req", int'(bus.map_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    chk("rst_Size", int'(Size), 6);

    // Eight frames right with an open map
    tot_reqs = 0;
    repeat (8) frame(8'h07);
    chk("right8_PosX", int'(PosX), 232);
    chk("right8_last_dirX", int'(last_dirX), 1);
    chk("right8_reqs", tot_reqs, 1);

    // Mid-tile reversal needs no probe
    do_reset();
    repeat (2) frame(8'h07);
    chk("rev_pre_PosX", int'(PosX), 220);
    frame(8'h04);
    chk("rev_PosX", int'(PosX), 218);
    chk("rev_reqs", req_cnt, 0);
    chk("rev_last_dirX", int'(last_dirX), 15);

    // Queued turn up taken at the next centre
    do_reset();
    repeat (2) frame(8'h07);
    repeat (6) frame(8'h1A);
    chk("turn_pre_PosX", int'(PosX), 232);
    chk("turn_pre_PosY", int'(PosY), 376);
    frame(8'h1A);
    chk("turn_PosX", int'(PosX), 232);
    chk("turn_PosY", int'(PosY), 374);
    chk("turn_last_dirY", int'(last_dirY), 15);
    chk("turn_last_dirX", int'(last_dirX), 0);
    chk("turn_reqs", req_cnt, 1);
    repeat (3) frame(8'h1A);
    chk("turn_up3_PosY", int'(PosY), 368);

    // Wall ahead stops the sprite at the tile centre
    do_reset();
    walls[23][15] = 1'b1;
    repeat (8) frame(8'h07);
    frame(8'h00);
    chk("wall_PosX", int'(PosX), 232);
    chk("wall_last_dirX", int'(last_dirX), 1);
    repeat (2) frame(8'h00);
    chk("wall_hold_PosX", int'(PosX), 232);
    walls[23][15] = 1'b0;

    // Reset while waiting on a turn answer; late answer must be ignored
    do_reset();
    resp_en = 1'b0;
    model_sync = 1'b0;
    keycode = 8'h07;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    cyc = 0;
    while (!bus.map_req && cyc < 20) begin
      @(negedge Clk);
      cyc++;
    end
    chk("wt_req_seen", int'(bus.map_req), 1);
    repeat (2) @(negedge Clk);
    chk("wt_busy_hold", int'(busy), 1);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    stale_cnt++;
    repeat (4) @(negedge Clk);
    chk("wt_PosX", int'(PosX), 216);
    chk("wt_busy", int'(busy), 0);
    chk("wt_last_dirX", int'(last_dirX), 0);
    chk("wt_map_req", int'(bus.map_req), 0);
    model_reset();
    model_sync = 1'b1;
    resp_en = 1'b1;
    frame(8'h00);
    chk("wt_after_PosX", int'(PosX), 216);

    // Frame tick while busy sets the sticky overrun flag
    frame_overrun(8'h00);
    chk("ovr_set", int'(tick_overrun), 1);
    frame(8'h00);
    chk("ovr_sticky", int'(tick_overrun), 1);
    do_reset();
    chk("ovr_cleared", int'(tick_overrun), 0);

    // Tunnel wrap in both directions
    repeat (72) frame(8'h1A);
    chk("tun_PosY", int'(PosY), 232);
    repeat (104) frame(8'h04);
    chk("tun_pre_PosX", int'(PosX), 8);
    frame(8'h00);
    chk("tun_wrap_left", int'(PosX), 632);
    chk("tun_wrap_reqs", req_cnt, 0);
    frame(8'h00);
    chk("tun_left_on", int'(PosX), 630);
    frame(8'h07);
    chk("tun_rev_right", int'(PosX), 632);
    frame(8'h00);
    chk("tun_wrap_right", int'(PosX), 8);

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pacman_mover.md
Name: pacman_mover

Overview:
- Grid-locked sprite motion controller. It is the parametrised successor to the free-moving ball block.
- Each frame it applies a keyboard direction request, checks walls through a tile-map query handshake, moves the sprite by SPEED pixels, and wraps through the tunnel row.
- It sits between the USB keycode path and the sprite/colour mapper. It runs on the system clock, with a one-cycle frame strobe.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- TILE, 16, tile edge in pixels; must be a power of two
- SPEED, 2, pixels moved per frame; must divide TILE
- SIZE, 6, sprite radius, driven on Size
- START_COL, 13, reset tile column
- START_ROW, 23, reset tile row
- TUNNEL_ROW, 14, row on which horizontal screen wrap is allowed

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- keycode  in  8  USB keycode: 0x1A up, 0x16 down, 0x04 left, 0x07 right; any other value means no request
- map_req  out  1  tile query request
- map_col  out  6  queried tile column
- map_row  out  6  queried tile row
- map_valid  in  1  query answer strobe
- map_wall  in  1  queried tile is a wall; sampled when map_valid=1
- PosX  out  10  sprite centre X
- PosY  out  10  sprite centre Y
- Size  out  10  constant SIZE
- last_dirX  out  4  4'h1 right, 4'hF left, 4'h0 otherwise
- last_dirY  out  4  4'h1 down, 4'hF up, 4'h0 otherwise
- busy  out  1  FSM not in IDLE
- tick_overrun  out  1  sticky: a frame_tick arrived while busy

Behaviour:
- Reset (Reset=0 at a Clk edge) overrides everything, including mid-query. Reset values:
  - PosX=START_COL*TILE+TILE/2, PosY=START_ROW*TILE+TILE/2
  - cur_dir=NONE, pend_dir=NONE, last_dirX=last_dirY=0
  - map_req=0, busy=0, tick_overrun=0, state=IDLE
  - A map_valid arriving after reset is ignored.
- Centred: (PosX mod TILE)==TILE/2 and (PosY mod TILE)==TILE/2.
- Tile of the sprite: col=PosX/TILE, row=PosY/TILE.
- FSM states: IDLE, LATCH, PROBE_TURN, WAIT_TURN, PROBE_FWD, WAIT_FWD, MOVE.
- IDLE:
  - frame_tick -> LATCH.
  - frame_tick while not IDLE is dropped and sets tick_overrun.
- LATCH (1 cycle):
  - A valid keycode overwrites pend_dir; an invalid keycode leaves pend_dir unchanged.
  - If pend_dir is the exact reverse of cur_dir: cur_dir<=pend_dir, pend_dir<=NONE, go to MOVE. No probe; reversal is legal mid-tile.
  - Else if centred and pend_dir!=NONE and pend_dir!=cur_dir -> PROBE_TURN.
  - Else if centred and cur_dir!=NONE -> PROBE_FWD.
  - Else -> MOVE.
- PROBE_TURN / PROBE_FWD:
  - Drive the neighbour tile (in pend_dir or cur_dir respectively) on map_col/map_row with map_req=1 for exactly one cycle, then go to WAIT_*.
  - Neighbour out of range: tunnel row with a horizontal step is open; any other out-of-range neighbour is a wall. No request is issued; the result is used as if answered.
- WAIT_* holds until map_valid. Answer latency is arbitrary, ≥1 cycle; there is no timeout.
- WAIT_TURN on open: cur_dir<=pend_dir, pend_dir<=NONE, -> MOVE.
- WAIT_TURN on wall: pend_dir is kept (queued turn), -> PROBE_FWD if cur_dir!=NONE, else IDLE.
- WAIT_FWD on wall: cur_dir<=NONE, -> IDLE.
- WAIT_FWD on open: -> MOVE.
- MOVE (1 cycle):
  - PosX/PosY step by ±SPEED in cur_dir. last_dirX/Y update from cur_dir and hold their value once stopped.
  - Then -> IDLE.
- Tunnel wrap:
  - On TUNNEL_ROW, moving left from PosX==TILE/2 sets PosX=SCREEN_W-TILE/2.
  - Moving right from SCREEN_W-TILE/2 sets PosX=TILE/2.
- Arithmetic: 10-bit unsigned. Off-row underflow cannot occur, because the border is wall.
- Worst case is ~6 cycles plus 2 map latencies per frame, well under the frame period.

Decomposition:
- Package pacman_pkg holds:
  - dir_t enum {NONE, UP, DOWN, LEFT, RIGHT}
  - keycode constants KEY_W, KEY_S, KEY_A, KEY_D
  - the state_t enum
  - function dir_reverse()
- Sub-module tile_neighbour: combinational. Takes col, row and a dir_t; returns neighbour col/row plus out_of_range and tunnel_open. It is instantiated once, fed from a mux of pend_dir/cur_dir.

Test Plan:
- Reset=0 for 2 cycles -> PosX=216, PosY=376, last_dirX=last_dirY=0, map_req=0, busy=0.
- keycode=0x07, map always open (map_valid one cycle after map_req), 8 frame_ticks -> PosX=232, last_dirX=4'h1, exactly 1 map_req per centred frame.
- Moving right with keycode=0x1A held from PosX=220; the up tile is open once centred at 232 -> PosX reaches 232, then PosY decreases by 2 per frame, last_dirY=4'hF, last_dirX=0.
- Wall ahead (map_wall=1) at the next centre -> PosX stops at the centre, cur_dir=NONE, last_dirX stays 4'h1, later frames issue no movement.
- Moving right mid-tile at PosX=220, keycode=0x04 -> next MOVE gives PosX=218 with no map_req that frame.
- TUNNEL_ROW (PosY=232), moving left at PosX=8 -> next frame PosX=632.
- Reset=0 asserted while in WAIT_TURN, then map_valid=1 after reset release -> reset values held, no state change from the stale answer.
- frame_tick pulsed while busy=1 -> tick_overrun=1, held until Reset.
